// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative shift-add multiply, restoring divide,
// multiply-accumulate/subtract and direct MTHI/MTLO writes.
module hilo_muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_e;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MTHI  = 4'd4,
      OP_MTLO  = 4'd5,
      OP_MADD  = 4'd6,
      OP_MADDU = 4'd7,
      OP_MSUB  = 4'd8,
      OP_MSUBU = 4'd9
   } op_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   // multiply: {partial product, remaining multiplier}; divide: {remainder, dividend}
   logic [W2-1:0]    work_q, work_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             is_div_q, is_div_d;
   logic             acc_add_q, acc_add_d;
   logic             acc_sub_q, acc_sub_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div_zero_q, div_zero_d;

   logic dec_mul, dec_div, dec_sgn, dec_add, dec_sub, dec_mthi, dec_mtlo;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      dec_mul  = 1'b0;
      dec_div  = 1'b0;
      dec_sgn  = 1'b0;
      dec_add  = 1'b0;
      dec_sub  = 1'b0;
      dec_mthi = 1'b0;
      dec_mtlo = 1'b0;
      case (op)
         OP_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
         OP_MULTU: dec_mul = 1'b1;
         OP_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
         OP_DIVU:  dec_div = 1'b1;
         OP_MTHI:  dec_mthi = 1'b1;
         OP_MTLO:  dec_mtlo = 1'b1;
         OP_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_add = 1'b1; end
         OP_MADDU: begin dec_mul = 1'b1; dec_add = 1'b1; end
         OP_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_sub = 1'b1; end
         OP_MSUBU: begin dec_mul = 1'b1; dec_sub = 1'b1; end
         default:  ;
      endcase
      mag_a = (dec_sgn && src_a[WIDTH-1]) ? (~src_a + WIDTH'(1)) : src_a;
      mag_b = (dec_sgn && src_b[WIDTH-1]) ? (~src_b + WIDTH'(1)) : src_b;
   end

   logic [WIDTH:0]   mul_sum, div_rem_sh, div_diff;
   logic [W2-1:0]    prod_s, mac_res;
   logic [WIDTH-1:0] quot_s, rem_s;

   always_comb begin
      mul_sum    = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
      div_rem_sh = work_q[W2-1:WIDTH-1];
      // bit WIDTH of the difference is the borrow: remainder < divisor
      div_diff   = div_rem_sh - {1'b0, opnd_q};
      prod_s     = neg_res_q ? (~work_q + W2'(1)) : work_q;
      if (acc_add_q)      mac_res = acc_q + prod_s;
      else if (acc_sub_q) mac_res = acc_q - prod_s;
      else                mac_res = prod_s;
      quot_s = neg_res_q ? (~work_q[WIDTH-1:0] + WIDTH'(1)) : work_q[WIDTH-1:0];
      rem_s  = neg_rem_q ? (~work_q[W2-1:WIDTH] + WIDTH'(1)) : work_q[W2-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      work_d     = work_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      dvd_d      = dvd_q;
      is_div_d   = is_div_q;
      acc_add_d  = acc_add_q;
      acc_sub_d  = acc_sub_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (dec_mthi) begin
                  hi_d = src_a;
               end else if (dec_mtlo) begin
                  lo_d = src_a;
               end else if (dec_mul || dec_div) begin
                  state_d    = S_CALC;
                  busy_d     = 1'b1;
                  cnt_d      = '0;
                  is_div_d   = dec_div;
                  acc_add_d  = dec_add;
                  acc_sub_d  = dec_sub;
                  neg_res_d  = dec_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_rem_d  = dec_sgn && dec_div && src_a[WIDTH-1];
                  div_zero_d = dec_div && (src_b == '0);
                  dvd_d      = src_a;
                  if (dec_div) begin
                     work_d = {{WIDTH{1'b0}}, mag_a};
                     opnd_d = mag_b;
                  end else begin
                     work_d = {{WIDTH{1'b0}}, mag_b};
                     opnd_d = mag_a;
                  end
                  if (dec_add || dec_sub) acc_d = {hi_q, lo_q};
               end
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               if (!div_diff[WIDTH]) work_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
               else                  work_d = {work_q[W2-2:0], 1'b0};
            end else begin
               work_d = {mul_sum, work_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = mac_res;
            end else if (div_zero_q) begin
               hi_d = dvd_q;
               lo_d = '1;
            end else begin
               hi_d = rem_s;
               lo_d = quot_s;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         work_q     <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         dvd_q      <= '0;
         is_div_q   <= 1'b0;
         acc_add_q  <= 1'b0;
         acc_sub_q  <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         work_q     <= work_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         dvd_q      <= dvd_d;
         is_div_q   <= is_div_d;
         acc_add_q  <= acc_add_d;
         acc_sub_q  <= acc_sub_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: arithmetic reference model with a fixed-latency
// result queue, checked every cycle, plus directed vectors with literal results.
module tb_hilo_muldiv_unit;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] src_a, src_b, hi, lo;
   logic         busy, done;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result of an operation computed with plain 64-bit arithmetic.
   function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
      longint sa, sb, q, rm;
      longint unsigned ua, ub, uq, urm;
      logic [63:0] p, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      if (o == 4'd0 || o == 4'd6 || o == 4'd8) p = sa * sb;
      else                                      p = ua * ub;
      case (o)
         4'd0, 4'd1: r = p;
         4'd6, 4'd7: r = acc + p;
         4'd8, 4'd9: r = acc - p;
         4'd2: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else begin
               q  = sa / sb;
               rm = sa % sb;
               r  = {rm[31:0], q[31:0]};
            end
         end
         4'd3: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else begin
               uq  = ua / ub;
               urm = ua % ub;
               r   = {urm[31:0], uq[31:0]};
            end
         end
         default: r = acc;
      endcase
      return r;
   endfunction

   // Reference: an accepted operation's result appears exactly W+1 edges later.
   logic [31:0] m_hi, m_lo;
   logic        m_busy, m_done;
   logic [63:0] m_pend;
   int          m_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_pend <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               {m_hi, m_lo} <= m_pend;
               m_busy       <= 1'b0;
               m_done       <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
         end else if (start) begin
            if (op == 4'd4) m_hi <= src_a;
            else if (op == 4'd5) m_lo <= src_a;
            else if (op <= 4'd9) begin
               m_pend <= model_result(op, src_a, src_b, {m_hi, m_lo});
               m_busy <= 1'b1;
               m_cnt  <= W + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
   end

   task automatic wait_done(input int cnt0, output int edge_idx);
      int cnt = cnt0;
      while (!done && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      if (!done) check("done_timeout", 64'd0, 64'd1);
      edge_idx = cnt - 1;
   endtask

   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int edge_idx);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, edge_idx);
   endtask

   task automatic mt_op(input logic [3:0] o, input logic [31:0] a);
      op    = o;
      src_a = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   typedef struct packed {
      logic [3:0]  o;
      logic [31:0] a, b, eh, el;
   } vec_t;

   vec_t vt [0:10] = '{
      '{4'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{4'd6, 32'hFFFF_FFFE, 32'h0000_0003, 32'h3FFF_FFFF, 32'hFFFF_FFFA},
      '{4'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
      '{4'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF},
      '{4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF},
      '{4'd9, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001},
      '{4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0002},
      '{4'd3, 32'h0000_0005, 32'h0000_0009, 32'h0000_0005, 32'h0000_0000},
      '{4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0004, 32'h8000_0000},
      '{4'd2, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'hC000_0000},
      '{4'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}
   };

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int e;
      start = 1'b0;
      op    = '0;
      src_a = '0;
      src_b = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      check("model_multu", model_result(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0),
            64'hFFFF_FFFE_0000_0001);
      check("model_div_ovf", model_result(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0),
            64'h0000_0000_8000_0000);
      check("model_div_neg", model_result(4'd2, 32'hFFFF_FFF9, 32'd2, 64'd0),
            64'hFFFF_FFFF_FFFF_FFFD);

      run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
      check("multu_latency", e, 33);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      run_op(4'd0, 32'hFFFF_FFFD, 32'd5, e);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);
      run_op(4'd2, 32'hFFFF_FFF9, 32'd2, e);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, e);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0);

      run_op(4'd3, 32'd100, 32'd0, e);
      check("divz_latency", e, 33);
      check("divz_lo", lo, 32'hFFFF_FFFF);
      check("divz_hi", hi, 32'h0000_0064);
      run_op(4'd3, 32'd100, 32'd7, e);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      mt_op(4'd4, 32'h1);
      mt_op(4'd5, 32'hFFFF_FFFF);
      check("mt_busy", busy, 0);
      check("mt_done", done, 0);
      check("mthi", hi, 32'h1);
      check("mtlo", lo, 32'hFFFF_FFFF);
      run_op(4'd7, 32'd1, 32'd1, e);
      check("maddu_hi", hi, 32'h2);
      check("maddu_lo", lo, 32'h0);
      run_op(4'd8, 32'd2, 32'd3, e);
      check("msub_hi", hi, 32'h1);
      check("msub_lo", lo, 32'hFFFF_FFFA);

      op = 4'd0; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      mt_op(4'd5, 32'h55);
      check("busy_mtlo_ignored", lo, 32'hFFFF_FFFA);
      check("busy_mid", busy, 1);
      wait_done(6, e);
      check("mid_latency", e, 33);
      check("mid_hi", hi, 32'h0);
      check("mid_lo", lo, 32'h3F);

      op = 4'd1; src_a = 32'd4; src_b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("accept_in_done", busy, 1);
      wait_done(1, e);
      check("done_cycle_latency", e, 33);
      check("done_cycle_lo", lo, 32'd20);

      op = 4'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("async_rst_hi", hi, 0);
      check("async_rst_lo", lo, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) begin
         @(negedge clk);
         check("no_done_after_rst", done, 0);
      end
      run_op(4'd1, 32'd2, 32'd3, e);
      check("post_rst_hi", hi, 32'h0);
      check("post_rst_lo", lo, 32'd6);

      for (int i = 0; i < 11; i++) begin
         run_op(vt[i].o, vt[i].a, vt[i].b, e);
         check($sformatf("vec%0d_latency", i), e, 33);
         check($sformatf("vec%0d_hi", i), hi, vt[i].eh);
         check($sformatf("vec%0d_lo", i), lo, vt[i].el);
      end

      mt_op(4'd12, 32'h1234);
      check("reserved_busy", busy, 0);
      check("reserved_hi", hi, 32'hFFFF_FFFF);
      check("reserved_lo", lo, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      check("reserved_no_done", done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
